// File: rtl/fwd_ctrl_if.sv
// ---------------------------------------------------------------------------
// fwd_ctrl_if
//
// Bundles the decode-slot request, the bypass-select results and the
// register-file write port of the forwarding / interlock controller.
//
// Decode side (driven by the master):
//   d_valid, d_src_a, d_src_b, d_use_a, d_use_b, d_dest, d_wr, d_load, flush
// Controller side (driven by the slave, i.e. fwd_ctrl):
//   mux3_sel, mux4_sel   operand A / B bypass select
//                        (0 regfile, 1 ibox_result3, 2 ibox_result4,
//                         3 mem_out, 4 m_reg_out)
//   stall, issue         decode hold / decode advance
//   rf_write_en, rf_write_addr   register-file write port (W slot)
//   stall_count          saturating stall-cycle counter, CNT_BITS wide
// ---------------------------------------------------------------------------
interface fwd_ctrl_if #(
  parameter int CNT_BITS = 16
);
  logic                d_valid;
  logic [4:0]          d_src_a;
  logic [4:0]          d_src_b;
  logic                d_use_a;
  logic                d_use_b;
  logic [4:0]          d_dest;
  logic                d_wr;
  logic                d_load;
  logic                flush;

  logic [2:0]          mux3_sel;
  logic [2:0]          mux4_sel;
  logic                stall;
  logic                issue;
  logic                rf_write_en;
  logic [4:0]          rf_write_addr;
  logic [CNT_BITS-1:0] stall_count;

  // Decode / pipeline-control side
  modport master (
    output d_valid, d_src_a, d_src_b, d_use_a, d_use_b,
           d_dest, d_wr, d_load, flush,
    input  mux3_sel, mux4_sel, stall, issue,
           rf_write_en, rf_write_addr, stall_count
  );

  // Forwarding controller side
  modport slave (
    input  d_valid, d_src_a, d_src_b, d_use_a, d_use_b,
           d_dest, d_wr, d_load, flush,
    output mux3_sel, mux4_sel, stall, issue,
           rf_write_en, rf_write_addr, stall_count
  );
endinterface

// File: rtl/fwd_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_ctrl
//
// Operand-forwarding and load-use interlock controller for the integer
// pipeline. Tracks in-flight destination registers through E3, E4, M and W,
// produces the bypass-mux selects for the register-fetch stage, stalls
// decode on load-use hazards, drives the register-file write port from the
// W slot and counts stall cycles (saturating).
//
// Ports:
//   clk    clock, all state updates on posedge
//   rst_n  asynchronous active-low reset
//   bus    fwd_ctrl_if.slave : decode request in, selects / stall / issue /
//          register-file write port / stall counter out
// ---------------------------------------------------------------------------
module fwd_ctrl #(
  parameter int CNT_BITS = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  fwd_ctrl_if.slave      bus
);

  // Bypass select encoding shared by both operand muxes
  localparam logic [2:0] SEL_RF   = 3'd0;
  localparam logic [2:0] SEL_E3   = 3'd1;
  localparam logic [2:0] SEL_E4   = 3'd2;
  localparam logic [2:0] SEL_MEM  = 3'd3;
  localparam logic [2:0] SEL_MREG = 3'd4;

  // r31 is the hard-wired discard register: never forwarded, never written
  localparam logic [4:0] REG_DISCARD = 5'd31;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       wr;
    logic       load;
  } slot_t;

  typedef struct packed {
    logic [2:0] sel;
    logic       hazard;
  } fwd_t;

  slot_t e3_q;
  slot_t e4_q;
  slot_t m_q;

  // The W slot only feeds the write port, so its load flag is not kept
  logic       w_valid_q;
  logic [4:0] w_dest_q;
  logic       w_wr_q;

  logic [CNT_BITS-1:0] stall_count_q;

  fwd_t fwd_a;
  fwd_t fwd_b;
  logic hazard;
  logic stall_c;
  logic issue_c;

  function automatic logic produces(input slot_t s, input logic [4:0] r);
    return s.valid && s.wr && (s.dest == r) && (r != REG_DISCARD);
  endfunction

  // Youngest producer wins. A load still in E3/E4 has no data to forward
  // yet, so it raises a hazard instead of a select; a load in M is taken
  // from mem_out, an ALU result in M from m_reg_out. W is never bypassed
  // because the regfile writes at negedge ahead of the second-half read.
  function automatic fwd_t resolve(input logic       used,
                                   input logic [4:0] r,
                                   input slot_t      e3,
                                   input slot_t      e4,
                                   input slot_t      m);
    fwd_t f;
    f.sel    = SEL_RF;
    f.hazard = 1'b0;
    if (used) begin
      if (produces(e3, r)) begin
        if (e3.load) f.hazard = 1'b1;
        else         f.sel    = SEL_E3;
      end else if (produces(e4, r)) begin
        if (e4.load) f.hazard = 1'b1;
        else         f.sel    = SEL_E4;
      end else if (produces(m, r)) begin
        f.sel = m.load ? SEL_MEM : SEL_MREG;
      end
    end
    return f;
  endfunction

  // Operand selects and the interlock decision
  always_comb begin
    fwd_a   = resolve(bus.d_use_a, bus.d_src_a, e3_q, e4_q, m_q);
    fwd_b   = resolve(bus.d_use_b, bus.d_src_b, e3_q, e4_q, m_q);
    hazard  = fwd_a.hazard | fwd_b.hazard;
    stall_c = bus.d_valid & ~bus.flush & hazard;
    issue_c = bus.d_valid & ~stall_c & ~bus.flush;
  end

  // While stalled the instruction does not advance, so both selects are
  // forced to the regfile path rather than left at a stale bypass code.
  assign bus.mux3_sel      = stall_c ? SEL_RF : fwd_a.sel;
  assign bus.mux4_sel      = stall_c ? SEL_RF : fwd_b.sel;
  assign bus.stall         = stall_c;
  assign bus.issue         = issue_c;
  assign bus.rf_write_en   = w_valid_q & w_wr_q & (w_dest_q != REG_DISCARD);
  assign bus.rf_write_addr = w_valid_q ? w_dest_q : 5'd0;
  assign bus.stall_count   = stall_count_q;

  // Tracking pipeline: shifts every cycle; E3 takes the decode instruction
  // on issue and a bubble otherwise (stall or flush).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e3_q      <= '0;
      e4_q      <= '0;
      m_q       <= '0;
      w_valid_q <= 1'b0;
      w_dest_q  <= 5'd0;
      w_wr_q    <= 1'b0;
    end else begin
      w_valid_q <= m_q.valid;
      w_dest_q  <= m_q.dest;
      w_wr_q    <= m_q.wr;
      m_q       <= e4_q;
      e4_q      <= e3_q;
      if (issue_c) begin
        e3_q.valid <= 1'b1;
        e3_q.dest  <= bus.d_dest;
        e3_q.wr    <= bus.d_wr;
        e3_q.load  <= bus.d_load;
      end else begin
        e3_q <= '0;
      end
    end
  end

  // Stall-cycle counter, sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else if (stall_c && (stall_count_q != {CNT_BITS{1'b1}})) begin
      stall_count_q <= stall_count_q + CNT_BITS'(1);
    end
  end

endmodule
